// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin arbiter.
// Holds the FSM state type, the requester count and the grant index width,
// plus a helper that turns an owner index into a one-hot vector.
package rr_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // One-hot vector with only bit 'id' set.
    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] vec;
        vec = {NUM_REQ{1'b0}};
        vec[id] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Rotating-priority search (module rr_pick).
// Ports:
//   req     - request vector, bit i = requester i
//   ptr     - index that has highest priority; priority falls ptr, ptr+1, ... mod 4
//   exclude - requesters that must not be chosen (the current owner on a hand-over)
//   id      - chosen requester index (0 when found=0)
//   found   - at least one eligible requester exists
module rr_pick
    import rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic [NUM_REQ-1:0] exclude,
    output logic [ID_W-1:0]    id,
    output logic               found
);

    logic [NUM_REQ-1:0] cand_s;
    logic [ID_W-1:0]    idx_s;

    // Walk from the lowest priority offset up to offset 0 so that the
    // candidate closest to ptr is the last one written and therefore wins.
    always_comb begin
        cand_s = req & ~exclude;
        id     = {ID_W{1'b0}};
        found  = 1'b0;
        idx_s  = {ID_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_s = ptr + ID_W'(k);
            if (cand_s[idx_s]) begin
                id    = idx_s;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter with a bounded hold time.
// A grant is issued one cycle after the request is sampled; the owner keeps
// the grant while it requests, but after MAX_HOLD consecutive cycles it is
// preempted if another requester is waiting. Dropping 'en' releases the grant.
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   req     - request vector, bit i = requester i
//   en      - arbitration enable, 0 releases any grant
//   gnt     - registered one-hot grant
//   gnt_id  - encoded owner index, valid when gnt_vld=1
//   gnt_vld - a grant is active
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_vld
);

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t             state_r, state_n;
    logic [ID_W-1:0]    owner_r, owner_n;
    logic [ID_W-1:0]    ptr_r,   ptr_n;
    logic [3:0]         cnt_r,   cnt_n;
    logic [NUM_REQ-1:0] gnt_r,   gnt_n;
    logic               vld_r,   vld_n;

    logic [NUM_REQ-1:0] owner_oh_s;
    logic [NUM_REQ-1:0] excl_s;
    logic               others_s;
    logic               keep_s;
    logic [ID_W-1:0]    pick_id_s;
    logic               pick_found_s;

    assign owner_oh_s = id_to_onehot(owner_r);
    // While busy, ptr already equals owner+1, so searching from ptr with the
    // owner masked out yields "next requester after owner".
    assign excl_s     = (state_r == BUSY) ? owner_oh_s : {NUM_REQ{1'b0}};
    assign others_s   = |(req & ~owner_oh_s);
    assign keep_s     = req[owner_r] && ((cnt_r < MAX_HOLD_C) || !others_s);

    rr_pick u_pick (
        .req     (req),
        .ptr     (ptr_r),
        .exclude (excl_s),
        .id      (pick_id_s),
        .found   (pick_found_s)
    );

    // Next-state, owner, pointer, hold counter and output computation.
    always_comb begin
        state_n = state_r;
        owner_n = owner_r;
        ptr_n   = ptr_r;
        cnt_n   = cnt_r;
        case (state_r)
            IDLE: begin
                if (en && pick_found_s) begin
                    state_n = BUSY;
                    owner_n = pick_id_s;
                    ptr_n   = pick_id_s + 2'd1;
                    cnt_n   = 4'd1;
                end else begin
                    state_n = IDLE;
                end
            end
            BUSY: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (keep_s) begin
                    cnt_n = (cnt_r < MAX_HOLD_C) ? (cnt_r + 4'd1) : cnt_r;
                end else if (pick_found_s) begin
                    owner_n = pick_id_s;
                    ptr_n   = pick_id_s + 2'd1;
                    cnt_n   = 4'd1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        vld_n = (state_n == BUSY);
        gnt_n = vld_n ? id_to_onehot(owner_n) : {NUM_REQ{1'b0}};
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            owner_r <= {ID_W{1'b0}};
            ptr_r   <= {ID_W{1'b0}};
            cnt_r   <= 4'd0;
            gnt_r   <= {NUM_REQ{1'b0}};
            vld_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            owner_r <= owner_n;
            ptr_r   <= ptr_n;
            cnt_r   <= cnt_n;
            gnt_r   <= gnt_n;
            vld_r   <= vld_n;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_id  = owner_r;
    assign gnt_vld = vld_r;

endmodule
